pulse_sequencer: RTL and testbench

Stream-driven sequencer for single-channel pulse generation. It accepts pulse descriptors (rise, fall, period) over an AXI4-Stream slave port and executes them back-to-back with no idle cycle between periods. It drives one registered pulse output and sits between a descriptor FIFO, fed by the PS or a DMA, and the GPIO/trigger fabric, replacing static register-programmed pulse timing.

---
 rtl/pulse_sequencer.sv | 133 +++++++++++++
 tb/tb_pulse_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: runs (rise, fall, period) descriptors taken from an AXI4-Stream slave back-to-back
// on one registered pulse output. Optional macro PULSE_SEQUENCER_REPEAT_EN re-runs the last descriptor on starvation.
module pulse_sequencer #(
   parameter int unsigned CNTR_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    enable,
   input  logic [3*CNTR_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic                    dout,
   output logic                    busy,
   output logic                    underflow,
   output logic [31:0]             pulse_count
);

   localparam int unsigned CW  = CNTR_WIDTH;
   localparam int unsigned PCW = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state;
   logic [CW-1:0]  cntr;
   logic [CW-1:0]  rise_r;
   logic [CW-1:0]  fall_r;
   logic [CW-1:0]  period_r;
   logic           dout_r;
   logic           busy_r;
   logic           underflow_r;
   logic [PCW-1:0] pulse_count_r;

   logic [CW-1:0]  rise_in;
   logic [CW-1:0]  fall_in;
   logic [CW-1:0]  period_in;
   logic           period_end;
   logic           load;
   logic           dout_nxt;

   assign rise_in    = s_axis_tdata[CW-1:0];
   assign fall_in    = s_axis_tdata[2*CW-1:CW];
   assign period_in  = s_axis_tdata[3*CW-1:2*CW];
   assign period_end = (cntr == period_r);

   // Accept only from IDLE or on the last cycle of a period, never while reset is held.
   always_comb begin
      s_axis_tready = 1'b0;
      if (aresetn) begin
         if (state == IDLE) s_axis_tready = enable;
         else               s_axis_tready = enable && period_end;
      end
   end

   assign load = s_axis_tvalid && s_axis_tready;

   // Level carries across period boundaries; fall match overrides rise match.
   always_comb begin
      dout_nxt = dout_r;
      if (cntr == rise_r) dout_nxt = 1'b1;
      if (cntr == fall_r) dout_nxt = 1'b0;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= IDLE;
         cntr          <= '0;
         rise_r        <= '0;
         fall_r        <= '0;
         period_r      <= '0;
         dout_r        <= 1'b0;
         busy_r        <= 1'b0;
         underflow_r   <= 1'b0;
         pulse_count_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               dout_r <= 1'b0;
               if (load) begin
                  rise_r   <= rise_in;
                  fall_r   <= fall_in;
                  period_r <= period_in;
                  cntr     <= '0;
                  state    <= RUN;
                  busy_r   <= 1'b1;
               end
            end
            RUN: begin
               if (!period_end) begin
                  cntr   <= cntr + CW'(1);
                  dout_r <= dout_nxt;
               end else begin
                  pulse_count_r <= pulse_count_r + PCW'(1);
                  if (load) begin
                     rise_r   <= rise_in;
                     fall_r   <= fall_in;
                     period_r <= period_in;
                     cntr     <= '0;
                     dout_r   <= dout_nxt;
                  end else if (enable) begin
                     underflow_r <= 1'b1;
`ifdef PULSE_SEQUENCER_REPEAT_EN
                     cntr        <= '0;
                     dout_r      <= dout_nxt;
`else
                     state       <= IDLE;
                     busy_r      <= 1'b0;
                     dout_r      <= 1'b0;
`endif
                  end else begin
                     state  <= IDLE;
                     busy_r <= 1'b0;
                     dout_r <= 1'b0;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
               dout_r <= 1'b0;
            end
         endcase
      end
   end

   assign dout        = dout_r;
   assign busy        = busy_r;
   assign underflow   = underflow_r;
   assign pulse_count = pulse_count_r;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios plus random stimulus against a timeline reference model.
module tb_pulse_sequencer;

   localparam int unsigned W = 32;

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic           enable = 1'b0;
   logic [3*W-1:0] s_axis_tdata = '0;
   logic           s_axis_tvalid = 1'b0;
   logic           s_axis_tready;
   logic           dout;
   logic           busy;
   logic           underflow;
   logic [31:0]    pulse_count;

   pulse_sequencer #(.CNTR_WIDTH(W)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .enable        (enable),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .dout          (dout),
      .busy          (busy),
      .underflow     (underflow),
      .pulse_count   (pulse_count)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the active descriptor and how many cycles of its period have elapsed.
   bit          m_active = 1'b0;
   int unsigned m_elapsed = 0;
   int unsigned m_rise = 0, m_fall = 0, m_len = 0;
   bit          m_level = 1'b0;
   bit          m_starved = 1'b0;
   logic [31:0] m_done = '0;

   function automatic bit m_ready();
      return aresetn && enable && (!m_active || m_elapsed == m_len);
   endfunction

   task automatic m_take(input logic [3*W-1:0] d);
      m_rise    = d[W-1:0];
      m_fall    = d[2*W-1:W];
      m_len     = d[3*W-1:2*W];
      m_elapsed = 0;
      m_active  = 1'b1;
   endtask

   task automatic m_edge();
      bit take, lvl;
      if (!aresetn) begin
         m_active = 0; m_elapsed = 0; m_rise = 0; m_fall = 0; m_len = 0;
         m_level = 0; m_starved = 0; m_done = '0;
         return;
      end
      take = s_axis_tvalid && m_ready();
      if (!m_active) begin
         m_level = 1'b0;
         if (take) m_take(s_axis_tdata);
         return;
      end
      lvl = m_level;
      if (m_elapsed == m_rise) lvl = 1'b1;
      if (m_elapsed == m_fall) lvl = 1'b0;
      if (m_elapsed < m_len) begin
         m_elapsed++;
         m_level = lvl;
      end else begin
         m_done = m_done + 32'd1;
         if (take) begin
            m_take(s_axis_tdata);
            m_level = lvl;
         end else if (enable) begin
            m_starved = 1'b1;
`ifdef PULSE_SEQUENCER_REPEAT_EN
            m_elapsed = 0;
            m_level   = lvl;
`else
            m_active = 1'b0;
            m_level  = 1'b0;
`endif
         end else begin
            m_active = 1'b0;
            m_level  = 1'b0;
         end
      end
   endtask

   int cyc = 0;
   int hs_q[$];
   int first_hi = -1, last_hi = -1, hi_cnt = 0;
   logic last_tready = 1'b0;

   task automatic clr();
      hs_q.delete();
      first_hi = -1; last_hi = -1; hi_cnt = 0;
   endtask

   // One clock: check the handshake signal mid-cycle, advance the model, check registered outputs.
   task automatic cycle();
      bit hs;
      @(negedge aclk);
      last_tready = s_axis_tready;
      chk("tready", 32'(s_axis_tready), 32'(m_ready()));
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      m_edge();
      cyc++;
      if (hs) hs_q.push_back(cyc);
      #1;
      chk("dout", 32'(dout), 32'(m_level));
      chk("busy", 32'(busy), 32'(m_active));
      chk("underflow", 32'(underflow), 32'(m_starved));
      chk("pulse_count", pulse_count, m_done);
      if (dout) begin
         if (first_hi < 0) first_hi = cyc;
         last_hi = cyc;
         hi_cnt++;
      end
   endtask

   task automatic do_reset();
      aresetn = 0; enable = 0; s_axis_tvalid = 0;
      cycle();
      aresetn = 1;
      clr();
   endtask

   function automatic logic [3*W-1:0] desc(input int unsigned r, input int unsigned f, input int unsigned p);
      return {W'(p), W'(f), W'(r)};
   endfunction

   initial begin
      int e0, n;
      logic [3*W-1:0] dl [3];

      do_reset();
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_uf", 32'(underflow), 32'd0);
      chk("rst_cnt", pulse_count, 32'd0);

      // Single descriptor, stream then starves
      enable = 1; s_axis_tvalid = 1; s_axis_tdata = desc(2, 5, 9);
      cycle(); e0 = cyc;
      s_axis_tvalid = 0;
      repeat (10) cycle();
      chk("t1_hs", 32'(hs_q.size()), 32'd1);
      chk("t1_first", 32'(first_hi - e0), 32'd3);
      chk("t1_last", 32'(last_hi - e0), 32'd5);
      chk("t1_hicnt", 32'(hi_cnt), 32'd3);
      chk("t1_count", pulse_count, 32'd1);
      chk("t1_uf", 32'(underflow), 32'd1);
`ifdef PULSE_SEQUENCER_REPEAT_EN
      chk("t1_busy", 32'(busy), 32'd1);
`else
      chk("t1_busy", 32'(busy), 32'd0);
`endif

      // Three back-to-back descriptors
      do_reset();
      dl[0] = desc(1, 3, 4); dl[1] = desc(0, 2, 2); dl[2] = desc(3, 4, 5);
      enable = 1; s_axis_tvalid = 1; n = 0;
      for (int k = 0; k < 20 && n < 3; k++) begin
         s_axis_tdata = dl[n];
         cycle();
         if (hs_q.size() > n) n++;
      end
      s_axis_tvalid = 0; enable = 0;
      chk("t2_nhs", 32'(hs_q.size()), 32'd3);
      if (hs_q.size() == 3) begin
         e0 = hs_q[0];
         chk("t2_hs1", 32'(hs_q[1] - e0), 32'd5);
         chk("t2_hs2", 32'(hs_q[2] - e0), 32'd8);
         for (int k = 0; k < 20 && cyc < e0 + 14; k++) cycle();
         chk("t2_count", pulse_count, 32'd3);
         chk("t2_busy", 32'(busy), 32'd0);
      end

      // Equal edges and out-of-range rise
      do_reset();
      enable = 1; s_axis_tvalid = 1; s_axis_tdata = desc(4, 4, 7);
      cycle();
      s_axis_tvalid = 0; enable = 0;
      repeat (9) cycle();
      chk("t3_eq_hicnt", 32'(hi_cnt), 32'd0);
      chk("t3_eq_count", pulse_count, 32'd1);
      clr();
      enable = 1; s_axis_tvalid = 1; s_axis_tdata = desc(8, 3, 7);
      cycle();
      s_axis_tvalid = 0; enable = 0;
      repeat (9) cycle();
      chk("t3_oor_hicnt", 32'(hi_cnt), 32'd0);
      chk("t3_oor_count", pulse_count, 32'd2);

      // Enable dropped mid-period with tvalid held high
      do_reset();
      enable = 1; s_axis_tvalid = 1; s_axis_tdata = desc(2, 5, 9);
      cycle();
      repeat (3) cycle();
      enable = 0;
      repeat (10) cycle();
      chk("t5_nhs", 32'(hs_q.size()), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_uf", 32'(underflow), 32'd0);
      chk("t5_count", pulse_count, 32'd1);
      s_axis_tvalid = 0;

      // Reset pulse mid-period while the pulse is high
      do_reset();
      enable = 1; s_axis_tvalid = 1; s_axis_tdata = desc(2, 8, 9);
      cycle();
      s_axis_tvalid = 0;
      repeat (4) cycle();
      chk("t6_pre_dout", 32'(dout), 32'd1);
      aresetn = 0; s_axis_tvalid = 1;
      cycle();
      chk("t6_tready", 32'(last_tready), 32'd0);
      chk("t6_dout", 32'(dout), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_cnt", pulse_count, 32'd0);
      aresetn = 1; s_axis_tvalid = 0; enable = 0;
      cycle();

`ifdef PULSE_SEQUENCER_REPEAT_EN
      do_reset();
      enable = 1; s_axis_tvalid = 1; s_axis_tdata = desc(1, 2, 3);
      cycle();
      s_axis_tvalid = 0;
      repeat (12) cycle();
      chk("rep_hicnt", 32'(hi_cnt), 32'd3);
      chk("rep_count", pulse_count, 32'd3);
      chk("rep_uf", 32'(underflow), 32'd1);
      chk("rep_busy", 32'(busy), 32'd1);
      enable = 0;
      repeat (5) cycle();
`endif

      // Random traffic against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         aresetn       = ($urandom_range(0, 199) != 0);
         enable        = ($urandom_range(0, 9) != 0);
         s_axis_tvalid = ($urandom_range(0, 2) != 0);
         s_axis_tdata  = desc($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 10));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
